upd_slow_phy_to_llr: RTL and testbench

Rate-adapting unpacker between the slow-PHY receive FIFOs and the LLR calculator. It pops 128-bit IQ and noise words from two FIFOs, then emits per strobe two resource elements (RE0/RE1 I and Q) plus the noise value for the current noise group. Each user is processed as a burst of `i_cur_user_re_amounts` REs. One noise sample covers `i_user_iq_noise_rate` REs.

---
 rtl/upd_slow_phy_to_llr_if.sv | 57 +++++
 rtl/upd_slow_phy_to_llr.sv | 189 ++++++++++++++++++
 tb/tb_upd_slow_phy_to_llr.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upd_slow_phy_to_llr_if.sv
// upd_slow_phy_to_llr_if: FIFO-side, config and LLR-side signals
// of the slow-PHY unpacker. slave = unpacker, master = its environment.
interface upd_slow_phy_to_llr_if;

    logic [15:0]  i_user_iq_noise_rate;
    logic [15:0]  i_cur_user_re_amounts;
    logic [127:0] IQ_Data_SUM;
    logic [127:0] Noise_Data_SUM;
    logic         IQ_FIFO_Empty;
    logic         Noise_FIFO_Empty;
    logic         IQ_FIFO_Read_Enable;
    logic         Noise_FIFO_Read_Enable;
    logic         Strobe_Enable;
    logic         o_data_strobe;
    logic [15:0]  o_re0_data_i;
    logic [15:0]  o_re0_data_q;
    logic [15:0]  o_re1_data_i;
    logic [15:0]  o_re1_data_q;
    logic [15:0]  o_noise_data;

    modport slave (
        input  i_user_iq_noise_rate,
        input  i_cur_user_re_amounts,
        input  IQ_Data_SUM,
        input  Noise_Data_SUM,
        input  IQ_FIFO_Empty,
        input  Noise_FIFO_Empty,
        output IQ_FIFO_Read_Enable,
        output Noise_FIFO_Read_Enable,
        output Strobe_Enable,
        output o_data_strobe,
        output o_re0_data_i,
        output o_re0_data_q,
        output o_re1_data_i,
        output o_re1_data_q,
        output o_noise_data
    );

    modport master (
        output i_user_iq_noise_rate,
        output i_cur_user_re_amounts,
        output IQ_Data_SUM,
        output Noise_Data_SUM,
        output IQ_FIFO_Empty,
        output Noise_FIFO_Empty,
        input  IQ_FIFO_Read_Enable,
        input  Noise_FIFO_Read_Enable,
        input  Strobe_Enable,
        input  o_data_strobe,
        input  o_re0_data_i,
        input  o_re0_data_q,
        input  o_re1_data_i,
        input  o_re1_data_q,
        input  o_noise_data
    );

endinterface

// File: rtl/upd_slow_phy_to_llr.sv
// upd_slow_phy_to_llr: unpacks 128-bit IQ/noise FIFO words into RE pairs.
// Define STROBE_HALF_RATE_EN to force an idle cycle after every strobe.
module upd_slow_phy_to_llr (
    input  logic                 i_core_clk,
    input  logic                 i_rx_rstn,
    input  logic                 i_rx_fsm_rstn,
    upd_slow_phy_to_llr_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RUN,
        S_REFILL,
        S_DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [15:0]  rate_q;
    logic [15:0]  rem_q;
    logic [15:0]  ncnt_q;
    logic [2:0]   lane_q;
    logic         half_q;
    logic         need_iq_q;
    logic         need_nz_q;
    logic [127:0] iq_word_q;
    logic [127:0] nz_word_q;

    logic         start;
    logic         refill_ok;
    logic         strobe;
    logic         last;
    logic         iq_re;
    logic         nz_re;
    logic [15:0]  rate_in;
    logic [15:0]  ncnt_nxt;
    logic [16:0]  ncnt_sum;
    logic [3:0]   lane_sum;
    logic [63:0]  iq_half;
    logic [15:0]  re1_i;
    logic [15:0]  re1_q;
    logic [15:0]  nz_val;

    assign rate_in = (bus.i_user_iq_noise_rate == 16'd0)
                   ? 16'd1 : bus.i_user_iq_noise_rate;

    assign start = (bus.i_cur_user_re_amounts != 16'd0)
                 && !bus.IQ_FIFO_Empty
                 && !bus.Noise_FIFO_Empty;

    assign refill_ok = (!need_iq_q || !bus.IQ_FIFO_Empty)
                     && (!need_nz_q || !bus.Noise_FIFO_Empty);

    assign last = rem_q <= 16'd2;

`ifdef STROBE_HALF_RATE_EN
    logic gap_q;

    assign strobe = (state == S_RUN) && !gap_q;

    always_ff @(posedge i_core_clk or negedge i_rx_fsm_rstn) begin
        if (!i_rx_fsm_rstn) gap_q <= 1'b0;
        else                gap_q <= strobe && (state_nxt == S_RUN);
    end
`else
    assign strobe = (state == S_RUN);
`endif

    // Lanes 0..3 feed the first strobe of a word, lanes 4..7 the second.
    assign iq_half = half_q ? iq_word_q[127:64] : iq_word_q[63:0];
    assign re1_i   = (rem_q == 16'd1) ? 16'd0 : iq_half[47:32];
    assign re1_q   = (rem_q == 16'd1) ? 16'd0 : iq_half[63:48];
    assign nz_val  = nz_word_q[{lane_q, 4'b0000} +: 16];

    // A rate of 1 spends two noise samples per strobe.
    always_comb begin
        ncnt_sum = {1'b0, ncnt_q} + 17'd2;
        ncnt_nxt = ncnt_sum[15:0];
        lane_sum = {1'b0, lane_q};
        if (rate_q == 16'd1) begin
            ncnt_nxt = 16'd0;
            lane_sum = {1'b0, lane_q} + 4'd2;
        end else if (ncnt_sum >= {1'b0, rate_q}) begin
            ncnt_nxt = ncnt_q + 16'd2 - rate_q;
            lane_sum = {1'b0, lane_q} + 4'd1;
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_fsm_rstn) begin
        if (!i_rx_fsm_rstn) begin
            state     <= S_IDLE;
            rate_q    <= 16'd0;
            rem_q     <= 16'd0;
            ncnt_q    <= 16'd0;
            lane_q    <= 3'd0;
            half_q    <= 1'b0;
            need_iq_q <= 1'b0;
            need_nz_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                rate_q    <= rate_in;
                rem_q     <= bus.i_cur_user_re_amounts;
                ncnt_q    <= 16'd0;
                lane_q    <= 3'd0;
                half_q    <= 1'b0;
                need_iq_q <= 1'b1;
                need_nz_q <= 1'b1;
            end else if (state == S_FETCH) begin
                need_iq_q <= 1'b0;
                need_nz_q <= 1'b0;
            end else if (strobe) begin
                rem_q     <= last ? 16'd0 : rem_q - 16'd2;
                ncnt_q    <= ncnt_nxt;
                lane_q    <= lane_sum[2:0];
                half_q    <= ~half_q;
                need_iq_q <= half_q && !last;
                need_nz_q <= lane_sum[3] && !last;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_RUN;
            S_RUN: begin
                if (strobe) begin
                    if (last)
                        state_nxt = S_DONE;
                    else if (half_q || lane_sum[3])
                        state_nxt = S_REFILL;
                end
            end
            S_REFILL: if (refill_ok) state_nxt = S_FETCH;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        iq_re = 1'b0;
        nz_re = 1'b0;
        unique case (state)
            S_IDLE: begin
                iq_re = start;
                nz_re = start;
            end
            S_REFILL: begin
                iq_re = refill_ok && need_iq_q;
                nz_re = refill_ok && need_nz_q;
            end
            default: ;
        endcase
    end

    assign bus.IQ_FIFO_Read_Enable    = iq_re && !bus.IQ_FIFO_Empty;
    assign bus.Noise_FIFO_Read_Enable = nz_re && !bus.Noise_FIFO_Empty;
    assign bus.Strobe_Enable          = strobe;

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            iq_word_q         <= '0;
            nz_word_q         <= '0;
            bus.o_data_strobe <= 1'b0;
            bus.o_re0_data_i  <= 16'd0;
            bus.o_re0_data_q  <= 16'd0;
            bus.o_re1_data_i  <= 16'd0;
            bus.o_re1_data_q  <= 16'd0;
            bus.o_noise_data  <= 16'd0;
        end else begin
            if (state == S_FETCH && need_iq_q)
                iq_word_q <= bus.IQ_Data_SUM;
            if (state == S_FETCH && need_nz_q)
                nz_word_q <= bus.Noise_Data_SUM;
            bus.o_data_strobe <= strobe;
            if (strobe) begin
                bus.o_re0_data_i <= iq_half[15:0];
                bus.o_re0_data_q <= iq_half[31:16];
                bus.o_re1_data_i <= re1_i;
                bus.o_re1_data_q <= re1_q;
                bus.o_noise_data <= nz_val;
            end
        end
    end

endmodule

// File: tb/tb_upd_slow_phy_to_llr.sv
// tb_upd_slow_phy_to_llr: scoreboard bench for the slow-PHY unpacker.
// Expected strobes are queued at burst start, compared as they emerge.
module tb_upd_slow_phy_to_llr;

    typedef struct packed {
        logic [15:0] r0i;
        logic [15:0] r0q;
        logic [15:0] r1i;
        logic [15:0] r1q;
        logic [15:0] nz;
    } exp_t;

    logic tb_sclk = 1'b0;
    logic rx_rstn;
    logic rx_fsm_rstn;

    always #5 tb_sclk = ~tb_sclk;

    upd_slow_phy_to_llr_if bus ();

    upd_slow_phy_to_llr dut (
        .i_core_clk    (tb_sclk),
        .i_rx_rstn     (rx_rstn),
        .i_rx_fsm_rstn (rx_fsm_rstn),
        .bus           (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   iq_pops = 0;
    int   n_pops  = 0;
    bit   pat_const = 1'b1;
    exp_t sbq[$];
    int   burst_id = 0;
    int   exp_ns, exp_iq, exp_nz;

    int se_cnt = 0, re_cnt = 0, viol = 0;
    int strobes = 0, extra = 0, adj = 0;
    int first_cyc = -1, gap1 = -1, last_cyc = -100;

    logic [79:0] obs;
    assign obs = {bus.o_re0_data_i, bus.o_re0_data_q,
                  bus.o_re1_data_i, bus.o_re1_data_q,
                  bus.o_noise_data};

    task automatic chk(input string tag,
                       input logic [127:0] act,
                       input logic [127:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, want);
        end
    endtask

    function automatic logic [15:0] lane_val(input bit nz,
                                             input int w,
                                             input int l);
        if (pat_const) begin
            case (l)
                0: return 16'h000C;
                1: return 16'h0011;
                2: return 16'h0022;
                3: return 16'h0033;
                4: return 16'h0044;
                5: return 16'h0055;
                6: return 16'h0066;
                default: return 16'h0077;
            endcase
        end
        if (nz) return 16'h8000 | 16'(w * 16 + l);
        return 16'(w * 16 + l + 1);
    endfunction

    function automatic logic [127:0] word(input bit nz, input int w);
        logic [127:0] v = '0;
        for (int l = 0; l < 8; l++) v[l*16 +: 16] = lane_val(nz, w, l);
        return v;
    endfunction

    always @(posedge tb_sclk) cyc <= cyc + 1;

    // Standard FIFOs: data appears the cycle after the pop.
    always @(posedge tb_sclk) begin
        if (bus.IQ_FIFO_Read_Enable) begin
            bus.IQ_Data_SUM <= word(1'b0, iq_pops);
            iq_pops <= iq_pops + 1;
        end
        if (bus.Noise_FIFO_Read_Enable) begin
            bus.Noise_Data_SUM <= word(1'b1, n_pops);
            n_pops <= n_pops + 1;
        end
    end

    // RE n uses IQ word n/4 and noise sample n/rate of the burst.
    task automatic push_burst(input int amt, input int rate,
                              input int ib, input int nb);
        int r, rem, g, w, h;
        exp_t e;
        r = (rate == 0) ? 1 : rate;
        exp_ns = (amt + 1) / 2;
        exp_iq = (exp_ns + 1) / 2;
        exp_nz = ((2 * (exp_ns - 1)) / r) / 8 + 1;
        for (int k = 0; k < exp_ns; k++) begin
            rem = amt - 2 * k;
            g = (2 * k) / r;
            w = ib + k / 2;
            h = 4 * (k % 2);
            e.r0i = lane_val(1'b0, w, h);
            e.r0q = lane_val(1'b0, w, h + 1);
            e.r1i = (rem >= 2) ? lane_val(1'b0, w, h + 2) : 16'h0;
            e.r1q = (rem >= 2) ? lane_val(1'b0, w, h + 3) : 16'h0;
            e.nz  = lane_val(1'b1, nb + g / 8, g % 8);
            sbq.push_back(e);
        end
    endtask

    task automatic mon_loop();
        exp_t e;
        int seen = 0;
        int sib = 0;
        forever begin
            @(negedge tb_sclk);
            if (bus.Strobe_Enable) se_cnt++;
            if (bus.IQ_FIFO_Read_Enable || bus.Noise_FIFO_Read_Enable)
                re_cnt++;
            if ((bus.IQ_FIFO_Read_Enable && bus.IQ_FIFO_Empty) ||
                (bus.Noise_FIFO_Read_Enable && bus.Noise_FIFO_Empty))
                viol++;
            if (bus.o_data_strobe) begin
                if (seen != burst_id) begin
                    seen = burst_id;
                    sib = 0;
                end
                if (sib == 0) first_cyc = cyc;
                else if (sib == 1) gap1 = cyc - last_cyc;
`ifdef STROBE_HALF_RATE_EN
                if (cyc - last_cyc == 1) adj++;
`endif
                sib++;
                strobes++;
                last_cyc = cyc;
                if (sbq.size() == 0) extra++;
                else begin
                    e = sbq.pop_front();
                    chk("strobe", obs, e);
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge tb_sclk);
        #1;
    endtask

    int ib, nb, c0, s0;

    task automatic start_burst(input int rate, input int amt);
        @(negedge tb_sclk);
        #1;
        ib = iq_pops;
        nb = n_pops;
        s0 = strobes;
        push_burst(amt, rate, ib, nb);
        burst_id++;
        bus.i_user_iq_noise_rate  = 16'(rate);
        bus.i_cur_user_re_amounts = 16'(amt);
        c0 = cyc;
        #1;
        chk("idle_pop", {bus.IQ_FIFO_Read_Enable,
                         bus.Noise_FIFO_Read_Enable}, 2'b11);
        @(posedge tb_sclk);
        #1;
        bus.i_cur_user_re_amounts = 16'd0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (sbq.size() != 0 && k < limit) begin
            @(negedge tb_sclk);
            k++;
        end
        chk("drain", sbq.size(), 0);
        step(6);
        chk("iq_pops", iq_pops - ib, exp_iq);
        chk("nz_pops", n_pops - nb, exp_nz);
        chk("strobe_cnt", strobes - s0, exp_ns);
    endtask

    int nsnap, isnap, ssnap, sesnap, rsnap;
    logic [79:0] osnap;

    initial begin
        rx_rstn = 1'b0;
        rx_fsm_rstn = 1'b0;
        bus.i_user_iq_noise_rate  = 16'd0;
        bus.i_cur_user_re_amounts = 16'd0;
        bus.IQ_FIFO_Empty    = 1'b1;
        bus.Noise_FIFO_Empty = 1'b1;
        fork
            mon_loop();
        join_none

        step(3);
        chk("rst_out", {bus.o_data_strobe, obs}, 81'd0);
        chk("rst_ctl", {bus.IQ_FIFO_Read_Enable,
                        bus.Noise_FIFO_Read_Enable,
                        bus.Strobe_Enable}, 3'd0);
        rx_rstn = 1'b1;
        rx_fsm_rstn = 1'b1;
        bus.IQ_FIFO_Empty    = 1'b0;
        bus.Noise_FIFO_Empty = 1'b0;
        bus.i_user_iq_noise_rate = 16'd6;

        rsnap = re_cnt;
        ssnap = strobes;
        step(20);
        chk("zero_re", re_cnt - rsnap, 0);
        chk("zero_strobe", strobes - ssnap, 0);

        pat_const = 1'b1;
        start_burst(6, 113);
        wait_done(2000);
        chk("latency", first_cyc - c0, 3);
`ifdef STROBE_HALF_RATE_EN
        chk("gap", gap1, 2);
`else
        chk("gap", gap1, 1);
`endif

        pat_const = 1'b0;
        start_burst(2, 200);
        step(10);
        bus.Noise_FIFO_Empty = 1'b1;
        nsnap = n_pops;
        step(12);
        bus.IQ_FIFO_Empty = 1'b1;
        isnap = iq_pops;
        step(20);
        ssnap = strobes;
        sesnap = se_cnt;
        osnap = obs;
        step(58);
        chk("stall_strobe", strobes - ssnap, 0);
        chk("stall_se", se_cnt - sesnap, 0);
        chk("stall_hold", obs, osnap);
        chk("nz_nopop", n_pops - nsnap, 0);
        bus.Noise_FIFO_Empty = 1'b0;
        step(80);
        chk("iq_nopop", iq_pops - isnap, 0);
        bus.IQ_FIFO_Empty = 1'b0;
        wait_done(3000);

        pat_const = 1'b1;
        start_burst(6, 40);
        step(10);
        chk("run_active", (strobes - s0) > 0, 1'b1);
        @(posedge tb_sclk);
        #3;
        rx_rstn = 1'b0;
        rx_fsm_rstn = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_out", {bus.o_data_strobe, obs}, 81'd0);
        chk("midrst_ctl", {bus.IQ_FIFO_Read_Enable,
                           bus.Noise_FIFO_Read_Enable,
                           bus.Strobe_Enable}, 3'd0);
        step(2);
        rx_rstn = 1'b1;
        rx_fsm_rstn = 1'b1;
        step(2);

        start_burst(1, 4);
        wait_done(200);

        chk("re_gated", viol, 0);
        chk("extra", extra, 0);
`ifdef STROBE_HALF_RATE_EN
        chk("adjacent", adj, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
